bcd_cascade_counter: RTL and testbench

Parametrised multi-digit up/down decade counter for the seven-segment display path. It generalises the single-digit 0–9 counter to NUM_DIGITS cascaded digits with a configurable per-digit modulus. It adds direction control, synchronous load and clear, and terminal-count outputs for chaining further stages. The counter sits between the prescaler/enable generator and the display multiplexer, which consumes `count` as packed 4-bit digits.

---
 rtl/bcd_counter_pkg.sv | 15 +
 rtl/bcd_digit.sv | 41 ++++
 rtl/bcd_cascade_counter.sv | 83 ++++++++
 tb/tb_bcd_cascade_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
// rtl/bcd_counter_pkg.sv - shared constants and digit sanitise helper for the cascaded decade counter
package bcd_counter_pkg;

    localparam int DIGIT_W        = 4;
    localparam int NUM_DIGITS_MIN = 1;
    localparam int NUM_DIGITS_MAX = 8;
    localparam int DIGIT_MOD_MIN  = 2;
    localparam int DIGIT_MOD_MAX  = 10;

    // Out-of-range digit codes are forced to zero so a digit can never leave 0..mod-1
    function automatic logic [DIGIT_W-1:0] sanitise(input logic [DIGIT_W-1:0] v, input int mod);
        return (int'(v) >= mod) ? '0 : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - single modulo-DIGIT_MOD up/down digit with clear and load
module bcd_digit
    import bcd_counter_pkg::*;
#(
    parameter int DIGIT_MOD = 10
) (
    input  logic               clk,
    input  logic               grst,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] ld_val,
    input  logic               step_in,
    input  logic               up,
    output logic [DIGIT_W-1:0] q,
    output logic               at_max,
    output logic               at_zero
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(DIGIT_MOD - 1);

    // Digit register: clear beats load beats step; a step wraps at either end of the range
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= sanitise(ld_val, DIGIT_MOD);
        end else if (step_in) begin
            if (up) begin
                q <= at_max ? '0 : q + DIGIT_W'(1);
            end else begin
                q <= at_zero ? MAX_V : q - DIGIT_W'(1);
            end
        end
    end

    assign at_max  = (q == MAX_V);
    assign at_zero = (q == '0);

endmodule

// File: rtl/bcd_cascade_counter.sv
// rtl/bcd_cascade_counter.sv - NUM_DIGITS cascaded up/down decade counter; BCD_CNT_SAT_EN selects saturating mode with sticky ovf
module bcd_cascade_counter
    import bcd_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_MOD  = 10
) (
    input  logic                          clk,
    input  logic                          grst,
    input  logic                          clr,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
    input  logic                          enable,
    input  logic                          up,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic                          carryout,
    output logic                          borrowout,
    output logic                          ovf
);

    if (NUM_DIGITS < NUM_DIGITS_MIN || NUM_DIGITS > NUM_DIGITS_MAX) begin : g_bad_digits
        $error("bcd_cascade_counter: NUM_DIGITS out of range");
    end
    if (DIGIT_MOD < DIGIT_MOD_MIN || DIGIT_MOD > DIGIT_MOD_MAX) begin : g_bad_mod
        $error("bcd_cascade_counter: DIGIT_MOD out of range");
    end

    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] at_zero;
    logic [NUM_DIGITS-1:0] step;
    logic [NUM_DIGITS:0]   pre_max;
    logic [NUM_DIGITS:0]   pre_zero;
    logic                  sat_hold;

    // pre_max[k]/pre_zero[k]: every digit below k is at its max/zero, i.e. digit k receives the ripple
    assign pre_max[0]  = 1'b1;
    assign pre_zero[0] = 1'b1;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        assign pre_max[k+1]  = pre_max[k] & at_max[k];
        assign pre_zero[k+1] = pre_zero[k] & at_zero[k];
        assign step[k]       = enable & ~sat_hold & (up ? pre_max[k] : pre_zero[k]);

        bcd_digit #(
            .DIGIT_MOD(DIGIT_MOD)
        ) u_digit (
            .clk    (clk),
            .grst   (grst),
            .clr    (clr),
            .load   (load),
            .ld_val (load_value[DIGIT_W*k +: DIGIT_W]),
            .step_in(step[k]),
            .up     (up),
            .q      (count[DIGIT_W*k +: DIGIT_W]),
            .at_max (at_max[k]),
            .at_zero(at_zero[k])
        );
    end

    // Terminal counts are combinational so a following stage can use them as its enable directly
    assign carryout  = enable & up & pre_max[NUM_DIGITS];
    assign borrowout = enable & ~up & pre_zero[NUM_DIGITS];

`ifdef BCD_CNT_SAT_EN
    // A terminal step would wrap; suppress it so the count sticks at the end of the range
    assign sat_hold = carryout | borrowout;

    // Sticky overflow: set by a suppressed terminal step, cleared only by clr or grst
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (!load && sat_hold) begin
            ovf <= 1'b1;
        end
    end
`else
    assign sat_hold = 1'b0;
    assign ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// tb/tb_bcd_cascade_counter.sv - self-checking bench for bcd_cascade_counter (4x mod-10 and 2x mod-6 instances)
module tb_bcd_cascade_counter;

`ifdef BCD_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        grst;
    logic        clr, load, enable, up;
    logic [15:0] load_value;
    logic [15:0] count;
    logic        carryout, borrowout, ovf;
    logic        clr6, load6, enable6, up6;
    logic [7:0]  lv6;
    logic [7:0]  count6;
    logic        co6, bo6, ovf6;

    int checks = 0;
    int errors = 0;

    int unsigned mval  [2];
    bit          movf  [2];
    int unsigned range [2] = '{10000, 36};
    int          nd    [2] = '{4, 2};
    int          mods  [2] = '{10, 6};

    logic [31:0] q_exp [$];

    always #5 clk = ~clk;

    bcd_cascade_counter #(.NUM_DIGITS(4), .DIGIT_MOD(10)) dut (
        .clk(clk), .grst(grst), .clr(clr), .load(load), .load_value(load_value),
        .enable(enable), .up(up), .count(count), .carryout(carryout),
        .borrowout(borrowout), .ovf(ovf)
    );

    bcd_cascade_counter #(.NUM_DIGITS(2), .DIGIT_MOD(6)) dut6 (
        .clk(clk), .grst(grst), .clr(clr6), .load(load6), .load_value(lv6),
        .enable(enable6), .up(up6), .count(count6), .carryout(co6),
        .borrowout(bo6), .ovf(ovf6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int unsigned v, input int n, input int m);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(x % m);
            x = x / m;
        end
        return r;
    endfunction

    function automatic int unsigned dec(input logic [31:0] p, input int n, input int m);
        int unsigned v;
        int unsigned d;
        v = 0;
        for (int i = n - 1; i >= 0; i--) begin
            d = 32'(p[4*i +: 4]);
            if (d >= m) d = 0;
            v = v * m + d;
        end
        return v;
    endfunction

    // One clocked step on instance w: check terminal counts now, predict, then compare after the edge
    task automatic drive(input int w, input bit c, input bit l, input logic [31:0] lv,
                         input bit e, input bit u);
        bit co_e, bo_e;
        if (w == 0) begin
            clr = c; load = l; load_value = lv[15:0]; enable = e; up = u;
        end else begin
            clr6 = c; load6 = l; lv6 = lv[7:0]; enable6 = e; up6 = u;
        end
        #1;
        co_e = e && u && (mval[w] == range[w] - 1);
        bo_e = e && !u && (mval[w] == 0);
        chk(w == 0 ? "carryout" : "carryout6", (w == 0) ? carryout : co6, co_e);
        chk(w == 0 ? "borrowout" : "borrowout6", (w == 0) ? borrowout : bo6, bo_e);
        if (c) begin
            mval[w] = 0;
            movf[w] = 1'b0;
        end else if (l) begin
            mval[w] = dec(lv, nd[w], mods[w]);
        end else if (e) begin
            if (co_e || bo_e) begin
                if (SAT) movf[w] = 1'b1;
                else     mval[w] = co_e ? 0 : range[w] - 1;
            end else begin
                mval[w] = u ? mval[w] + 1 : mval[w] - 1;
            end
        end
        q_exp.push_back(enc(mval[w], nd[w], mods[w]));
        @(posedge clk);
        #1;
        if (w == 0) begin
            chk("count", {16'd0, count}, q_exp.pop_front());
            chk("ovf", ovf, SAT ? movf[0] : 1'b0);
        end else begin
            chk("count6", {24'd0, count6}, q_exp.pop_front());
            chk("ovf6", ovf6, SAT ? movf[1] : 1'b0);
        end
    endtask

    initial begin
        grst = 1'b1;
        clr = 0; load = 0; load_value = '0; enable = 0; up = 0;
        clr6 = 0; load6 = 0; lv6 = '0; enable6 = 0; up6 = 0;
        mval = '{0, 0};
        movf = '{1'b0, 1'b0};
        #12;
        chk("rst_count", {16'd0, count}, 32'h0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_carry", carryout, 1'b0);
        chk("rst_count6", {24'd0, count6}, 32'h0);
        enable = 1'b1;
        #1;
        chk("rst_borrow_en_down", borrowout, 1'b1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        grst = 1'b0;

        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1, 1);
        chk("cnt10", {16'd0, count}, 32'h0010);
        while (mval[0] != 9999) drive(0, 0, 0, 0, 1, 1);
        chk("cnt9999", {16'd0, count}, 32'h9999);
        drive(0, 0, 0, 0, 1, 1);
        drive(0, 1, 0, 0, 0, 0);

        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0);

        drive(0, 0, 1, 32'h12F7, 1, 1);
        chk("load_sanitise", {16'd0, count}, 32'h1207);
        drive(0, 1, 1, 32'h5555, 1, 1);
        chk("clr_over_load", {16'd0, count}, 32'h0);
        drive(0, 0, 1, 32'h0999, 1, 0);
        drive(0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 1);

        drive(0, 0, 1, 32'h0455, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
        chk("cnt0456", {16'd0, count}, 32'h0456);
        enable = 1'b0;
        #2 grst = 1'b1;
        #1;
        chk("grst_async", {16'd0, count}, 32'h0);
        mval[0] = 0;
        movf[0] = 1'b0;
        mval[1] = 0;
        movf[1] = 1'b0;
        #1 grst = 1'b0;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 1, 1);
        chk("after_grst", {16'd0, count}, 32'h0001);

        drive(0, 0, 1, 32'h9999, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 1, 32'h0000, 1, 1);
        drive(0, 1, 0, 0, 0, 0);
        enable = 1'b0;

        drive(1, 0, 1, 32'h55, 0, 0);
        drive(1, 0, 0, 0, 1, 1);
        drive(1, 0, 1, 32'h7C, 0, 0);
        chk("load6_sanitise", {24'd0, count6}, 32'h0);
        for (int i = 0; i < 100; i++) begin
            drive(1, 0, 0, 0, bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)));
            chk("dig6_lo_range", {31'd0, count6[3:0] < 4'd6}, 32'h1);
            chk("dig6_hi_range", {31'd0, count6[7:4] < 4'd6}, 32'h1);
        end
        drive(1, 1, 0, 0, 0, 0);
        enable6 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
